mpe_result_packer: RTL

Downstream writeback stage for `matrix_pe`.
- Collects the 32-bit dot-product results that `matrix_pe` emits on `result`/`vld_o`, one at a time and without backpressure.
- Packs them into 512-bit output-RAM lines of 16 lanes each.
- Buffers completed lines in a small FIFO and presents them with a valid/ready write port and an auto-incrementing line address.

---
 rtl/mpe_pkg.sv | 16 +
 rtl/mpe_result_packer_if.sv | 28 ++
 rtl/mpe_wb_fifo.sv | 51 +++++
 rtl/mpe_result_packer.sv | 111 +++++++++++
 4 files changed

// File: rtl/mpe_pkg.sv
// Shared types and constants for the matrix_pe result writeback path.
// A line carries packed lane data, a lane-valid mask and its RAM line address.
package mpe_pkg;

    localparam int MPE_DATA_W = 32;
    localparam int MPE_LANES  = 16;
    localparam int MPE_LINE_W = MPE_DATA_W * MPE_LANES;
    localparam int MPE_ADDR_W = 16;

    typedef struct packed {
        logic [MPE_LINE_W-1:0] data;
        logic [MPE_LANES-1:0]  mask;
        logic [MPE_ADDR_W-1:0] addr;
    } mpe_wb_line_t;

endpackage

// File: rtl/mpe_result_packer_if.sv
// Output-RAM line write port: valid/ready handshake with data, mask and address.
// The packer drives it as master; the RAM-side consumer is the slave.
interface mpe_result_packer_if;
    import mpe_pkg::*;

    logic [MPE_LINE_W-1:0] wb_data;
    logic [MPE_LANES-1:0]  wb_mask;
    logic [MPE_ADDR_W-1:0] wb_addr;
    logic                  wb_valid;
    logic                  wb_ready;

    modport master (
        output wb_data,
        output wb_mask,
        output wb_addr,
        output wb_valid,
        input  wb_ready
    );

    modport slave (
        input  wb_data,
        input  wb_mask,
        input  wb_addr,
        input  wb_valid,
        output wb_ready
    );

endinterface

// File: rtl/mpe_wb_fifo.sv
// Small synchronous FIFO of completed writeback lines.
// Push while full is only accepted when a pop frees a slot in the same cycle.
module mpe_wb_fifo
    import mpe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  mpe_wb_line_t din,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output mpe_wb_line_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    mpe_wb_line_t mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB tells full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign head = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/mpe_result_packer.sv
// Packs matrix_pe results into 16-lane output-RAM lines and queues them
// for a valid/ready line write port with an auto-incrementing address.
module mpe_result_packer
    import mpe_pkg::*;
#(
    parameter int DATA_W     = MPE_DATA_W,
    parameter int LANES      = MPE_LANES,
    parameter int ADDR_W     = MPE_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pe_result,
    input  logic              pe_vld_i,
    input  logic              flush,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              base_load,
    mpe_result_packer_if.master wb,
    output logic              overflow,
    output logic              busy
);

    localparam int LINE_W = DATA_W * LANES;
    localparam int CW     = $clog2(LANES);

    logic [LINE_W-1:0] asm_data;
    logic [LINE_W-1:0] nxt_data;
    logic [LANES-1:0]  asm_mask;
    logic [LANES-1:0]  nxt_mask;
    logic [CW-1:0]     lane_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    logic fill;
    logic push;
    logic pop;
    logic accept;
    logic full;
    logic empty;

    mpe_wb_line_t push_line;
    mpe_wb_line_t head;

    // A strobe lands in the line before any push, so flush+strobe sees it.
    always_comb begin
        nxt_data = asm_data;
        nxt_mask = asm_mask;
        for (int i = 0; i < LANES; i++) begin
            if (pe_vld_i && lane_cnt == CW'(i)) begin
                nxt_data[i*DATA_W +: DATA_W] = pe_result;
                nxt_mask[i] = 1'b1;
            end
        end
    end

    assign fill   = pe_vld_i && (lane_cnt == CW'(LANES - 1));
    assign push   = fill || (flush && (pe_vld_i || lane_cnt != '0));
    assign pop    = wb.wb_valid && wb.wb_ready;
    assign accept = push && (!full || pop);

    assign push_line = '{data: nxt_data, mask: nxt_mask, addr: addr_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_data <= '0;
            asm_mask <= '0;
            lane_cnt <= '0;
            addr_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                asm_data <= '0;
                asm_mask <= '0;
                lane_cnt <= '0;
            end else if (pe_vld_i) begin
                asm_data <= nxt_data;
                asm_mask <= nxt_mask;
                lane_cnt <= lane_cnt + CW'(1);
            end

            if (base_load) begin
                addr_cnt <= base_addr;
            end else if (accept) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end

            if (push && !accept) overflow <= 1'b1;
        end
    end

    mpe_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (push_line),
        .full  (full),
        .pop   (pop),
        .empty (empty),
        .head  (head)
    );

    // Gate the head so the port reads all-zero whenever no line is offered.
    assign wb.wb_valid = !empty;
    assign wb.wb_data  = empty ? '0 : head.data;
    assign wb.wb_mask  = empty ? '0 : head.mask;
    assign wb.wb_addr  = empty ? '0 : head.addr;

    assign busy = (lane_cnt != '0) || !empty;

endmodule
